// File: rtl/riscv_rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port; one-entry output stage with read-port forwarding.
// Transfer edge N drives rf_we during cycle N+1; only hold or reset deassert ready, the output stage never stalls.
module riscv_rf_wr_arbiter #(
    parameter int N_REQ = 3,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [5*N_REQ-1:0]    req_addr,
    input  logic [XLEN*N_REQ-1:0] req_data,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic [4:0]            fwd_addr1,
    input  logic [4:0]            fwd_addr2,
    output logic                  fwd_hit1,
    output logic                  fwd_hit2,
    output logic [XLEN-1:0]       fwd_data1,
    output logic [XLEN-1:0]       fwd_data2,
    output logic [CNT_W-1:0]      contention_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] r_last_gnt;
    logic             r_we;
    logic [4:0]       r_waddr;
    logic [XLEN-1:0]  r_wdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt_vld;
    logic [IDX_W-1:0] w_gnt_idx;
    logic             w_xfer;
    logic             w_contend;
    logic [4:0]       w_sel_addr;
    logic [XLEN-1:0]  w_sel_data;

    // Rotating-priority search starting just past the last winner.
    always_comb begin : p_arb
        int               scan;
        logic [IDX_W-1:0] scan_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan     = (int'(r_last_gnt) + 1 + k) % N_REQ;
            scan_idx = IDX_W'(scan);
            if (!w_gnt_vld && req_valid[scan_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = scan_idx;
            end
        end
    end

    assign w_xfer     = w_gnt_vld && !hold && !rst;
    assign req_ready  = w_xfer ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_sel_addr = req_addr[5*w_gnt_idx +: 5];
    assign w_sel_data = req_data[XLEN*w_gnt_idx +: XLEN];
    assign w_contend  = $countones(req_valid) >= 2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= IDX_W'(N_REQ - 1);
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_xfer) begin
                r_last_gnt <= w_gnt_idx;
                r_waddr    <= w_sel_addr;
                r_wdata    <= w_sel_data;
                // x0 writes consume the grant but never reach the register file
                r_we       <= (w_sel_addr != 5'd0);
            end else begin
                r_we <= 1'b0;
            end
            if (w_contend && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rf_we          = r_we;
    assign rf_waddr       = r_waddr;
    assign rf_wdata       = r_wdata;
    assign contention_cnt = r_cnt;

    assign fwd_hit1  = r_we && (fwd_addr1 != 5'd0) && (fwd_addr1 == r_waddr);
    assign fwd_hit2  = r_we && (fwd_addr2 != 5'd0) && (fwd_addr2 == r_waddr);
    assign fwd_data1 = fwd_hit1 ? r_wdata : '0;
    assign fwd_data2 = fwd_hit2 ? r_wdata : '0;

endmodule

// File: tb/tb_riscv_rf_wr_arbiter.sv
// Scoreboarded bench for riscv_rf_wr_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_riscv_rf_wr_arbiter;

    localparam int N  = 3;
    localparam int XW = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_addr;
    logic [XW*N-1:0] req_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XW-1:0]   rf_wdata;
    logic [4:0]      fwd_addr1, fwd_addr2;
    logic            fwd_hit1, fwd_hit2;
    logic [XW-1:0]   fwd_data1, fwd_data2;
    logic [CW-1:0]   contention_cnt;

    riscv_rf_wr_arbiter #(.N_REQ(N), .XLEN(XW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // requester-side stimulus state
    bit          v[N];
    logic [4:0]  a[N];
    logic [31:0] d[N];
    bit          h;
    logic [4:0]  f1, f2;

    // reference model state
    int          m_last;
    int          m_cnt;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic void check(string name, longint unsigned act, longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_last  = N - 1;
        m_cnt   = 0;
        m_we    = 0;
        m_waddr = '0;
        m_wdata = '0;
        q.delete();
        for (int i = 0; i < N; i++) v[i] = 0;
    endfunction

    // Called at a falling edge: drive, check combinational outputs, predict, advance one cycle.
    task automatic step();
        int         g;
        int         nv;
        int         idx;
        logic [N-1:0] exp_rdy;
        bit         hit;
        exp_t       e;
        hold      = h;
        fwd_addr1 = f1;
        fwd_addr2 = f2;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = v[i];
            req_addr[5*i +: 5]    = a[i];
            req_data[XW*i +: XW]  = d[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_last + 1 + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_rdy = '0;
        if (!h && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("contention_cnt", contention_cnt, m_cnt);
        hit = m_we && f1 != 0 && f1 == m_waddr;
        check("fwd_hit1", fwd_hit1, hit);
        check("fwd_data1", fwd_data1, hit ? m_wdata : 0);
        hit = m_we && f2 != 0 && f2 == m_waddr;
        check("fwd_hit2", fwd_hit2, hit);
        check("fwd_data2", fwd_data2, hit ? m_wdata : 0);
        nv = 0;
        for (int i = 0; i < N; i++) nv += v[i];
        if (nv >= 2 && m_cnt < CMAX) m_cnt++;
        if (!h && g >= 0) begin
            m_we    = (a[g] != 0);
            m_waddr = a[g];
            m_wdata = d[g];
            m_last  = g;
            v[g]    = 0;
        end else begin
            m_we = 0;
        end
        e.we = m_we; e.addr = m_waddr; e.data = m_wdata;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        #1;
        check("rst_rf_we", rf_we, 0);
        check("rst_cnt", contention_cnt, 0);
        check("rst_ready", req_ready, 0);
        model_reset();
        h = 0; f1 = 0; f2 = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each falling edge reflects the output stage loaded at the preceding rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("rf_we", rf_we, mon_e.we);
            check("rf_waddr", rf_waddr, mon_e.addr);
            check("rf_wdata", rf_wdata, mon_e.data);
        end
    end

    initial begin
        rst = 1'b1; hold = 1'b0; h = 0; f1 = 0; f2 = 0;
        fwd_addr1 = '0; fwd_addr2 = '0;
        req_valid = '1; req_addr = '1; req_data = '1;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        @(posedge clk);
        @(negedge clk);
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_waddr", rf_waddr, 0);
        check("reset_rf_wdata", rf_wdata, 0);
        check("reset_cnt", contention_cnt, 0);
        check("reset_ready", req_ready, 0);
        model_reset();
        rst = 1'b0;

        // single request from requester 1
        v[1] = 1; a[1] = 5; d[1] = 32'hDEADBEEF;
        step(); step(); step();

        // all requesters valid for six cycles
        do_reset();
        repeat (6) begin
            for (int i = 0; i < N; i++) begin
                v[i] = 1; a[i] = 5'($urandom_range(1, 31)); d[i] = $urandom;
            end
            step();
        end
        for (int i = 0; i < N; i++) v[i] = 0;
        step();
        check("cnt_after_all_valid", contention_cnt, 6);

        // write to x0
        v[2] = 1; a[2] = 0; d[2] = 32'h1234;
        step(); step();

        // forwarding of an in-flight x7 write
        v[0] = 1; a[0] = 7; d[0] = 32'hA5A5A5A5;
        step();
        f1 = 7; f2 = 8;
        step();
        f1 = 0; f2 = 0;

        // hold freezes grants but not the output stage
        v[0] = 1; a[0] = 9; d[0] = 32'h0BADF00D;
        step();
        h = 1;
        v[0] = 1; a[0] = 10; d[0] = 32'h11111111;
        v[1] = 1; a[1] = 11; d[1] = 32'h22222222;
        step(); step(); step();
        h = 0;
        step(); step(); step();

        // counter saturation
        for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = 5'(i + 12); d[i] = 32'(i); end
        h = 1;
        repeat (20) step();
        check("cnt_saturated", contention_cnt, CMAX);
        h = 0;
        for (int i = 0; i < N; i++) v[i] = 0;

        // reset while rf_we is high
        v[0] = 1; a[0] = 3; d[0] = 32'h77;
        step();
        check("rf_we_before_rst", rf_we, 1);
        req_valid = '1;
        rst = 1'b1;
        #1;
        check("midrst_rf_we", rf_we, 0);
        check("midrst_cnt", contention_cnt, 0);
        check("midrst_ready", req_ready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin v[i] = 1; a[i] = 5'(i + 20); d[i] = $urandom; end
        step();
        for (int i = 0; i < N; i++) v[i] = 0;
        step();

        // random traffic
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i] = 1;
                    a[i] = 5'($urandom_range(0, 31));
                    d[i] = $urandom;
                end
            end
            h  = ($urandom_range(0, 7) == 0);
            f1 = ($urandom_range(0, 1) == 1) ? m_waddr : 5'($urandom_range(0, 31));
            f2 = ($urandom_range(0, 1) == 1) ? m_waddr : 5'($urandom_range(0, 31));
            step();
        end
        h = 0;
        repeat (N + 1) step();
        for (int i = 0; i < N; i++) v[i] = 0;
        step();
        #1;
        check("scoreboard_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
